// File: rtl/xrst_sla_settle_engine.sv
// Smart-SLA settlement engine: weights a reliability score, classifies it into a tier,
// deducts stake and streams one settlement beat per participant. Option: XRST_SETTLE_RESID_EN.
module xrst_sla_settle_engine #(
  parameter int N_PART    = 4,
  parameter int NUM_TIERS = 4,
  parameter int DW        = 32,
  parameter int WW        = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_sel,
  input  logic [$clog2(NUM_TIERS)-1:0] cfg_tier,
  input  logic [$clog2(N_PART)-1:0]    cfg_part,
  input  logic [DW-1:0]                cfg_wdata,
  output logic                         cfg_err,
  input  logic                         stake_load,
  input  logic [DW-1:0]                stake_value,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                rel_score,
  input  logic [WW-1:0]                w_avail,
  input  logic [WW-1:0]                w_lat,
  input  logic [WW-1:0]                w_corr,
  input  logic [DW-1:0]                credit_tokens,
  input  logic [DW-1:0]                penalty_tokens,
  input  logic [DW-1:0]                stake_adj,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_PART)-1:0]    out_part,
  output logic [DW-1:0]                out_amount,
  output logic                         out_last,
  output logic [$clog2(NUM_TIERS)-1:0] out_tier,
  output logic [7:0]                   out_status,
  output logic [DW-1:0]                remaining_stake,
  output logic                         busy
);

  localparam int TW    = $clog2(NUM_TIERS);
  localparam int PW    = $clog2(N_PART);
  localparam int SW    = 9;
  localparam int PRODW = DW + WW + 2;

  typedef enum logic [1:0] {IDLE, SCORE, CLASSIFY, EMIT} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] thr   [NUM_TIERS];
  logic [2:0]    mode  [NUM_TIERS];
  logic [SW-1:0] share [NUM_TIERS][N_PART];

  logic [DW-1:0] rel_q, credit_q, penalty_q, adj_q;
  logic [WW-1:0] wa_q, wl_q, wc_q;
  logic [DW-1:0] score_q, pool_q, stake_q;
  logic          sat_q;
  logic [TW-1:0] tier_q;
  logic [7:0]    status_q;
  logic [PW-1:0] part_q;

  logic [WW+1:0]  wsum_c;
  logic [PRODW-1:0] prod_c;
  logic [TW-1:0]  tier_c;
  logic           pen_c, floor_c, exhaust_c;
  logic [1:0]     mult_c;
  logic [DW+1:0]  ded_c;
  logic [DW-1:0]  stake_new_c, amt_c, final_c;
  logic [SW-1:0]  share_c;
  logic           is_last, emit_hs;

  assign is_last = (part_q == PW'(N_PART - 1));
  assign emit_hs = (state == EMIT) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = SCORE;
      SCORE:    state_nxt = CLASSIFY;
      CLASSIFY: state_nxt = EMIT;
      EMIT:     if (out_ready && is_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Weighted score: the product is kept at full width so overflow can be detected before truncation.
  always_comb begin
    wsum_c = (WW+2)'(wa_q) + (WW+2)'(wl_q) + (WW+2)'(wc_q);
    prod_c = ((PRODW)'(rel_q) * (PRODW)'(wsum_c)) >> 10;
  end

  always_comb begin
    tier_c = TW'(NUM_TIERS - 1);
    for (int t = NUM_TIERS - 1; t >= 0; t--) begin
      if (score_q >= thr[t]) tier_c = TW'(t);
    end
    pen_c       = mode[tier_c][0];
    mult_c      = mode[tier_c][2:1];
    ded_c       = (DW+2)'(adj_q) * (DW+2)'(mult_c);
    floor_c     = ded_c > (DW+2)'(stake_q);
    stake_new_c = floor_c ? '0 : DW'((DW+2)'(stake_q) - ded_c);
    exhaust_c   = floor_c || ((stake_new_c == '0) && (mult_c != 2'd0));
  end

`ifdef XRST_SETTLE_RESID_EN
  logic [DW-1:0]    acc_q;
  logic [SW+PW:0]   share_sum;

  // With a full 256/256 split the last beat absorbs whatever truncation left behind.
  always_comb begin
    share_c   = share[tier_q][part_q];
    amt_c     = DW'(((DW+SW)'(pool_q) * (DW+SW)'(share_c)) >> 8);
    share_sum = '0;
    for (int p = 0; p < N_PART; p++) share_sum = share_sum + (SW+PW+1)'(share[tier_q][p]);
    final_c   = (is_last && (share_sum == (SW+PW+1)'(256))) ? pool_q - acc_q : amt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 acc_q <= '0;
    else if (state == CLASSIFY) acc_q <= '0;
    else if (emit_hs)           acc_q <= acc_q + amt_c;
  end
`else
  always_comb begin
    share_c = share[tier_q][part_q];
    amt_c   = DW'(((DW+SW)'(pool_q) * (DW+SW)'(share_c)) >> 8);
    final_c = amt_c;
  end
`endif

  // Configuration is only writable while idle so a record always sees one consistent table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      for (int t = 0; t < NUM_TIERS; t++) begin
        thr[t]  <= (t == 0) ? DW'(950) : (t == 1) ? DW'(900) : (t == 2) ? DW'(800) : '0;
        mode[t] <= (t < 2) ? 3'b000 : (t == 2) ? 3'b011 : 3'b101;
        for (int p = 0; p < N_PART; p++) share[t][p] <= (p == 0) ? SW'(256) : '0;
      end
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if ((state != IDLE) || (cfg_sel == 2'd3)) begin
          cfg_err <= 1'b1;
        end else begin
          case (cfg_sel)
            2'd0:    thr[cfg_tier] <= cfg_wdata;
            2'd1:    mode[cfg_tier] <= cfg_wdata[2:0];
            default: share[cfg_tier][cfg_part] <= cfg_wdata[SW-1:0];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= '0; credit_q <= '0; penalty_q <= '0; adj_q <= '0;
      wa_q <= '0; wl_q <= '0; wc_q <= '0;
      score_q <= '0; sat_q <= 1'b0; pool_q <= '0; stake_q <= '0;
      tier_q <= '0; status_q <= '0; part_q <= '0;
    end else begin
      if ((state == IDLE) && stake_load) stake_q <= stake_value;
      case (state)
        IDLE: begin
          if (in_valid) begin
            rel_q <= rel_score; credit_q <= credit_tokens; penalty_q <= penalty_tokens;
            adj_q <= stake_adj; wa_q <= w_avail; wl_q <= w_lat; wc_q <= w_corr;
          end
        end
        SCORE: begin
          sat_q   <= |prod_c[PRODW-1:DW];
          score_q <= (|prod_c[PRODW-1:DW]) ? '1 : prod_c[DW-1:0];
        end
        CLASSIFY: begin
          tier_q   <= tier_c;
          pool_q   <= pen_c ? penalty_q : credit_q;
          stake_q  <= stake_new_c;
          status_q <= {5'b0, sat_q, exhaust_c, pen_c};
          part_q   <= '0;
        end
        EMIT: begin
          if (out_ready) part_q <= is_last ? '0 : part_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready        = (state == IDLE);
  assign busy            = (state != IDLE);
  assign out_valid       = (state == EMIT);
  assign out_last        = out_valid && is_last;
  assign out_amount      = out_valid ? final_c : '0;
  assign out_part        = part_q;
  assign out_tier        = tier_q;
  assign out_status      = status_q;
  assign remaining_stake = stake_q;

endmodule

// File: tb/tb_xrst_sla_settle_engine.sv
// Self-checking bench for xrst_sla_settle_engine: a record-level model predicts every beat,
// a negedge compare process checks them, and directed records pin the model with literals.
module tb_xrst_sla_settle_engine;

  localparam int N_PART = 4, NUM_TIERS = 4, DW = 32, WW = 11;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0, stake_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0] cfg_sel = '0, cfg_tier = '0, cfg_part = '0;
  logic [DW-1:0] cfg_wdata = '0, stake_value = '0, rel_score = '0;
  logic [DW-1:0] credit_tokens = '0, penalty_tokens = '0, stake_adj = '0;
  logic [WW-1:0] w_avail = '0, w_lat = '0, w_corr = '0;
  logic cfg_err, in_ready, out_valid, out_last, busy;
  logic [1:0] out_part, out_tier;
  logic [DW-1:0] out_amount, remaining_stake;
  logic [7:0] out_status;

  xrst_sla_settle_engine #(.N_PART(N_PART), .NUM_TIERS(NUM_TIERS), .DW(DW), .WW(WW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_tier(cfg_tier),
    .cfg_part(cfg_part), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .stake_load(stake_load),
    .stake_value(stake_value), .in_valid(in_valid), .in_ready(in_ready), .rel_score(rel_score),
    .w_avail(w_avail), .w_lat(w_lat), .w_corr(w_corr), .credit_tokens(credit_tokens),
    .penalty_tokens(penalty_tokens), .stake_adj(stake_adj), .out_valid(out_valid),
    .out_ready(out_ready), .out_part(out_part), .out_amount(out_amount), .out_last(out_last),
    .out_tier(out_tier), .out_status(out_status), .remaining_stake(remaining_stake), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     part;
    longint amount;
    bit     last;
    int     tier;
    int     status;
  } beat_t;

  beat_t  exp_q[$];
  beat_t  cur;
  longint obs_amt[$];
  int     passed = 0, total = 0;

  longint m_thr[NUM_TIERS];
  int     m_mode[NUM_TIERS];
  int     m_share[NUM_TIERS][N_PART];
  longint m_stake;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic longint obs_at(input int i);
    return (i < obs_amt.size()) ? obs_amt[i] : -1;
  endfunction

  task automatic model_defaults();
    for (int t = 0; t < NUM_TIERS; t++) begin
      m_thr[t]  = (t == 0) ? 950 : (t == 1) ? 900 : (t == 2) ? 800 : 0;
      m_mode[t] = (t < 2) ? 0 : (t == 2) ? 3 : 5;
      for (int p = 0; p < N_PART; p++) m_share[t][p] = (p == 0) ? 256 : 0;
    end
    m_stake = 0;
  endtask

  // Whole-record prediction straight from the settlement rules.
  task automatic model_record(input longint rel, input longint wa, input longint wl, input longint wc,
                              input longint credit, input longint penalty, input longint adj);
    longint score, pool, ded, sum_amt, amt[N_PART];
    int tier, sat, pen, mult, exh, ssum;
    bit found;
    beat_t b;
    score = (rel * (wa + wl + wc)) / 1024;
    sat = 0;
    if (score > 64'hFFFF_FFFF) begin score = 64'hFFFF_FFFF; sat = 1; end
    tier = NUM_TIERS - 1; found = 0;
    for (int t = 0; t < NUM_TIERS; t++)
      if (!found && score >= m_thr[t]) begin tier = t; found = 1; end
    pen  = m_mode[tier] & 1;
    mult = (m_mode[tier] >> 1) & 3;
    pool = pen ? penalty : credit;
    ded  = adj * mult;
    if (ded > m_stake) begin m_stake = 0; exh = 1; end
    else begin m_stake = m_stake - ded; exh = (m_stake == 0 && mult != 0) ? 1 : 0; end
    sum_amt = 0; ssum = 0;
    for (int p = 0; p < N_PART; p++) begin
      amt[p] = ((pool * m_share[tier][p]) >> 8) & 64'hFFFF_FFFF;
      sum_amt += amt[p];
      ssum += m_share[tier][p];
    end
`ifdef XRST_SETTLE_RESID_EN
    if (ssum == 256) amt[N_PART-1] = (amt[N_PART-1] + pool - sum_amt) & 64'hFFFF_FFFF;
`endif
    for (int p = 0; p < N_PART; p++) begin
      b.part = p; b.amount = amt[p]; b.last = (p == N_PART - 1);
      b.tier = tier; b.status = pen | (exh << 1) | (sat << 2);
      exp_q.push_back(b);
    end
  endtask

  // Every presented beat is compared against the head of the prediction queue.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) checkOutput("unexpected_beat", 1, 0);
      else begin
        cur = exp_q[0];
        checkOutput("beat_part", out_part, cur.part);
        checkOutput("beat_amount", out_amount, cur.amount);
        checkOutput("beat_last", out_last, cur.last);
        checkOutput("beat_tier", out_tier, cur.tier);
        checkOutput("beat_status", out_status, cur.status);
        if (out_ready) begin
          obs_amt.push_back(out_amount);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cfg_write(input int sel, input int tier, input int part, input longint data, input bit ok);
    cfg_sel = sel[1:0]; cfg_tier = tier[1:0]; cfg_part = part[1:0]; cfg_wdata = DW'(data); cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checkOutput("cfg_err", cfg_err, ok ? 0 : 1);
    if (ok) begin
      if (sel == 0) m_thr[tier] = data;
      else if (sel == 1) m_mode[tier] = int'(data) & 7;
      else m_share[tier][part] = int'(data);
    end
  endtask

  task automatic applyStimulus(input longint rel, input longint wa, input longint wl, input longint wc,
                               input longint credit, input longint penalty, input longint adj,
                               input int stall_beat, input int stall_cycles, input bit busy_write);
    int lat, cyc, stalls;
    longint held;
    model_record(rel, wa, wl, wc, credit, penalty, adj);
    obs_amt.delete();
    rel_score = DW'(rel); w_avail = WW'(wa); w_lat = WW'(wl); w_corr = WW'(wc);
    credit_tokens = DW'(credit); penalty_tokens = DW'(penalty); stake_adj = DW'(adj);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    if (busy_write) begin
      cfg_write(0, 0, 0, 2000, 1'b0);
      lat = 2;
    end
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checkOutput("first_valid_latency", lat, 3);
    cyc = 0; stalls = 0; held = 0;
    while (busy && cyc < 200) begin
      if (stalls < stall_cycles && (stalls > 0 || (out_valid && out_part == stall_beat))) begin
        if (stalls == 0) held = out_amount;
        else begin
          checkOutput("stall_valid", out_valid, 1);
          checkOutput("stall_part", out_part, stall_beat);
          checkOutput("stall_amount", out_amount, held);
        end
        checkOutput("stall_in_ready", in_ready, 0);
        out_ready = 1'b0;
        stalls++;
      end else out_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    if (cyc >= 200) checkOutput("emit_timeout", 0, 1);
    checkOutput("stall_count", stalls, stall_cycles);
    checkOutput("in_ready_after_last", in_ready, 1);
    checkOutput("beats_consumed", exp_q.size(), 0);
    checkOutput("remaining_stake", remaining_stake, m_stake);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    model_defaults();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_stake", remaining_stake, 0);
    checkOutput("reset_cfg_err", cfg_err, 0);
    checkOutput("reset_status", out_status, 0);
    checkOutput("reset_amount", out_amount, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] split record on tier 0");
    cfg_write(2, 0, 0, 128, 1'b1);
    cfg_write(2, 0, 1, 77, 1'b1);
    cfg_write(2, 0, 2, 51, 1'b1);
    cfg_write(2, 0, 3, 0, 1'b1);
    applyStimulus(1000, 1024, 0, 0, 1000, 0, 0, -1, 0, 1'b0);
    checkOutput("t0_beat0", obs_at(0), 500);
    checkOutput("t0_beat1", obs_at(1), 300);
    checkOutput("t0_beat2", obs_at(2), 199);
`ifdef XRST_SETTLE_RESID_EN
    checkOutput("t0_beat3", obs_at(3), 1);
`else
    checkOutput("t0_beat3", obs_at(3), 0);
`endif
    checkOutput("t0_tier", out_tier, 0);
    checkOutput("t0_status", out_status, 0);

    $display("[TB] penalty record with stake deduction");
    stake_value = 5000; stake_load = 1'b1;
    @(posedge clk); #1;
    stake_load = 1'b0;
    m_stake = 5000;
    checkOutput("stake_loaded", remaining_stake, 5000);
    applyStimulus(850, 512, 256, 256, 7, 400, 100, -1, 0, 1'b0);
    checkOutput("t2_stake", remaining_stake, 4900);
    checkOutput("t2_tier", out_tier, 2);
    checkOutput("t2_status", out_status, 1);
    checkOutput("t2_beat0", obs_at(0), 400);

    applyStimulus(500, 1024, 0, 0, 7, 400, 3000, -1, 0, 1'b0);
    checkOutput("t3_stake", remaining_stake, 0);
    checkOutput("t3_tier", out_tier, 3);
    checkOutput("t3_status", out_status, 3);

    $display("[TB] backpressure on beat 1");
    applyStimulus(1000, 1024, 0, 0, 1000, 0, 0, 1, 5, 1'b0);
    checkOutput("bp_beat1", obs_at(1), 300);

    $display("[TB] config writes while busy and with reserved select");
    applyStimulus(1000, 1024, 0, 0, 1000, 0, 0, -1, 0, 1'b1);
    applyStimulus(1000, 1024, 0, 0, 1000, 0, 0, -1, 0, 1'b0);
    checkOutput("thr_kept_tier", out_tier, 0);
    checkOutput("thr_kept_beat0", obs_at(0), 500);
    cfg_write(3, 0, 0, 5, 1'b0);

    $display("[TB] saturated score");
    applyStimulus(64'hFFFF_FFFF, 2047, 2047, 2047, 1000, 0, 0, -1, 0, 1'b0);
    checkOutput("sat_status", out_status, 4);

    $display("[TB] reset during EMIT");
    stake_value = 777; stake_load = 1'b1;
    @(posedge clk); #1;
    stake_load = 1'b0;
    m_stake = 777;
    model_record(1000, 1024, 0, 0, 1000, 0, 0);
    rel_score = 1000; w_avail = 1024; w_lat = 0; w_corr = 0; credit_tokens = 1000; stake_adj = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin @(posedge clk); #1; k++; end
    checkOutput("rst_emit_reached", out_valid, 1);
    checkOutput("rst_pre_stake", remaining_stake, 777);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_stake", remaining_stake, 0);
    exp_q.delete();
    model_defaults();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1000, 1024, 0, 0, 1000, 0, 0, -1, 0, 1'b0);
    checkOutput("post_rst_beat0", obs_at(0), 1000);
    checkOutput("post_rst_tier", out_tier, 0);
    applyStimulus(920, 1024, 0, 0, 1000, 0, 0, -1, 0, 1'b0);
    checkOutput("post_rst_tier1", out_tier, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
